rs_alu_scheduler: RTL and testbench
===================================

// Module: rs_alu_scheduler
// PURPOSE
//  Reservation-station scheduler in front of the ALU execute unit. Holds dispatched ALU/branch/jump ops,
//  snoops both CDBs (ALU, LSB) for operand wakeup, picks one ready entry per cycle (lowest index wins)
//  and drives the registered issue bundle (openum, V1, V2, imm, pc, rob_id) to the ALU. Sits between decoder/dispatch and the ALU.
// PARAMETERS
//  RS_SIZE      16  number of entries (power of two)
//  RS_IDX_W     4   log2(RS_SIZE)
//  ROB_ID_W     4   width of ROB tag carried in Q1/Q2 and rob_id
// PORTS
//  clk_in          in   1         clock, rising edge
//  rst_n           in   1         asynchronous reset, active-low
//  rdy_in          in   1         global ready; 0 = freeze all state
//  clear_in        in   1         mispredict flush: drop every entry
//  disp_valid_in   in   1         dispatch one op this cycle
//  disp_openum_in  in   OPENUM_W  operation enum
//  disp_V1_in/V2   in   32 each   operand values (meaningful if Qx_busy=0)
//  disp_Q1_busy/Q2 in   1 each    operand still pending
//  disp_Q1_in/Q2   in   ROB_ID_W  producing ROB tag when busy
//  disp_imm_in     in   32        immediate
//  disp_pc_in      in   32        instruction pc
//  disp_rob_id_in  in   ROB_ID_W  destination ROB tag
//  cdb_alu_valid / cdb_lsb_valid  in 1      broadcast valid
//  cdb_alu_rob_id / cdb_lsb_rob_id in ROB_ID_W  broadcast tag
//  cdb_alu_value / cdb_lsb_value  in 32     broadcast value
//  rs_full_out     out  1         no free entry (combinational from busy vector)
//  ex_openum_out   out  OPENUM_W  registered; OPENUM_NOP when nothing issued
//  ex_V1/V2/imm/pc_out out 32     registered issue operands
//  ex_rob_id_out   out  ROB_ID_W  registered destination tag
// BEHAVIOUR
//  - Reset (rst_n=0, async): all busy=0, ex_openum_out=OPENUM_NOP, other ex_* = 0, rs_full_out=0.
//  - Per entry: busy, openum, V1,Q1_busy,Q1, V2,Q2_busy,Q2, imm, pc, rob_id. ready = busy & !Q1_busy & !Q2_busy.
//  - Dispatch: if disp_valid_in & !rs_full_out, write lowest-index free entry (pre-edge busy). Dispatch while full is dropped.
//  - Dispatch bypass: if disp_Qx_busy and a same-cycle CDB tag matches disp_Qx_in, capture CDB value, Qx_busy=0.
//  - Wakeup: each busy entry with Qx_busy and tag match on either CDB takes value, clears Qx_busy. ALU CDB wins if both match.
//  - Issue: each edge, lowest-index ready entry (pre-edge state) -> ex_* registers, busy cleared. None ready -> ex_openum_out=OPENUM_NOP.
//  - Latency: dispatch with ready operands at edge t -> ex_* valid after edge t+1. CDB wakeup at edge t -> eligible at edge t+1.
//  - Issue and dispatch same edge: freed slot not reused that edge (free slot chosen from pre-edge busy).
//  - clear_in=1: all busy=0, ex_openum_out=OPENUM_NOP next cycle; overrides dispatch, issue and wakeup.
//  - rdy_in=0 (and clear_in=0): entries hold; ex_openum_out=OPENUM_NOP; no dispatch, wakeup or issue.
//  - Priority per edge: reset > clear_in > !rdy_in > normal.
//  - Operand values stored untouched, 32-bit; no arithmetic in this block.
// STRUCTURE
//  - Shared defines: OPENUM_W, OPENUM_NOP, DATA/ADDR widths, ROB_ID_W, RS_SIZE, TRUE/FALSE.
//  - Sub-module rs_pick_lowest: RS_SIZE-bit request vector -> found flag + RS_IDX_W index;
//    instantiated twice (free-slot pick over ~busy, issue pick over ready).
// TESTING
//  1 Reset mid-stream: 3 entries busy, rst_n low -> ex_openum_out=NOP immediately, rs_full_out=0, no issue after release.
//  2 Dispatch ADDI V1=5 imm=7 ready at edge t -> ex_openum=ADDI, V1=5, imm=7 after edge t+1; NOP after t+2.
//  3 Dispatch ADD Q1=tag3 busy; cdb_alu tag3 value 0x10 two cycles later -> issued with V1=0x10 one edge after broadcast.
//  4 Dispatch with Q2=tag5 while cdb_lsb tag5 value 0xFF same cycle -> bypass, issues next edge with V2=0xFF.
//  5 Fill 16 entries all pending -> rs_full_out=1; 17th dispatch dropped; wake entry 9 then 2 -> issue order 9, 2.
//  6 8 entries busy, clear_in=1 with disp_valid_in=1 -> all dropped, ex_openum=NOP, rs_full_out=0; rdy_in=0 holds state.

Source files
------------

// File: rtl/rs_alu_scheduler_pkg.sv
// Shared types and constants for the ALU reservation-station scheduler.
// Each entry holds an op, its two operands with their pending tags, and its payload.
package rs_alu_scheduler_pkg;

  localparam int RS_SIZE   = 16;
  localparam int RS_IDX_W  = 4;
  localparam int ROB_ID_W  = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int OPENUM_W  = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OPENUM_W-1:0] {
    OPENUM_NOP = 6'd0,
    OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
    OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
    OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
    OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
    OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
  } openum_e;

  typedef struct packed {
    logic                busy;
    logic [ROB_ID_W-1:0] tag;
    logic [DATA_W-1:0]   val;
  } operand_t;

  typedef struct packed {
    openum_e             openum;
    operand_t            op1;
    operand_t            op2;
    logic [DATA_W-1:0]   imm;
    logic [ADDR_W-1:0]   pc;
    logic [ROB_ID_W-1:0] rob_id;
  } rs_entry_t;

  typedef struct packed {
    openum_e             openum;
    logic [DATA_W-1:0]   v1;
    logic [DATA_W-1:0]   v2;
    logic [DATA_W-1:0]   imm;
    logic [ADDR_W-1:0]   pc;
    logic [ROB_ID_W-1:0] rob_id;
  } ex_bundle_t;

  // A pending operand takes the first matching CDB value; the ALU bus is checked first.
  function automatic operand_t snoop(
    input operand_t            op,
    input logic                alu_valid,
    input logic [ROB_ID_W-1:0] alu_tag,
    input logic [DATA_W-1:0]   alu_val,
    input logic                lsb_valid,
    input logic [ROB_ID_W-1:0] lsb_tag,
    input logic [DATA_W-1:0]   lsb_val
  );
    operand_t res;
    res = op;
    if (op.busy) begin
      if (alu_valid && (alu_tag == op.tag)) begin
        res.val  = alu_val;
        res.busy = FALSE;
      end else if (lsb_valid && (lsb_tag == op.tag)) begin
        res.val  = lsb_val;
        res.busy = FALSE;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_alu_scheduler_pick.sv
// Lowest-index priority picker: reports whether any request bit is set and
// the index of the lowest one.
module rs_pick_lowest
  import rs_alu_scheduler_pkg::*;
#(
  parameter int N     = RS_SIZE,
  parameter int IDX_W = RS_IDX_W
) (
  input  logic [N-1:0]     req_in,
  output logic             found_out,
  output logic [IDX_W-1:0] idx_out
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    found_out = FALSE;
    idx_out   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        found_out = TRUE;
        idx_out   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: accepts dispatched ops, wakes operands from both
// CDBs, and issues the lowest-index ready entry into a registered ALU bundle.
module rs_alu_scheduler
  import rs_alu_scheduler_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                rdy_in,
  input  logic                clear_in,

  input  logic                disp_valid_in,
  input  logic [OPENUM_W-1:0] disp_openum_in,
  input  logic [DATA_W-1:0]   disp_V1_in,
  input  logic [DATA_W-1:0]   disp_V2_in,
  input  logic                disp_Q1_busy,
  input  logic                disp_Q2_busy,
  input  logic [ROB_ID_W-1:0] disp_Q1_in,
  input  logic [ROB_ID_W-1:0] disp_Q2_in,
  input  logic [DATA_W-1:0]   disp_imm_in,
  input  logic [ADDR_W-1:0]   disp_pc_in,
  input  logic [ROB_ID_W-1:0] disp_rob_id_in,

  input  logic                cdb_alu_valid,
  input  logic [ROB_ID_W-1:0] cdb_alu_rob_id,
  input  logic [DATA_W-1:0]   cdb_alu_value,
  input  logic                cdb_lsb_valid,
  input  logic [ROB_ID_W-1:0] cdb_lsb_rob_id,
  input  logic [DATA_W-1:0]   cdb_lsb_value,

  output logic                rs_full_out,
  output logic [OPENUM_W-1:0] ex_openum_out,
  output logic [DATA_W-1:0]   ex_V1_out,
  output logic [DATA_W-1:0]   ex_V2_out,
  output logic [DATA_W-1:0]   ex_imm_out,
  output logic [ADDR_W-1:0]   ex_pc_out,
  output logic [ROB_ID_W-1:0] ex_rob_id_out
);

  logic [RS_SIZE-1:0]  busy_q, busy_d;
  rs_entry_t           ent_q [RS_SIZE];
  rs_entry_t           ent_d [RS_SIZE];
  ex_bundle_t          ex_q, ex_d;

  logic [RS_SIZE-1:0]  ready;
  logic                free_found, issue_found;
  logic [RS_IDX_W-1:0] free_idx, issue_idx;
  rs_entry_t           new_ent;

  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy_q[i] & ~ent_q[i].op1.busy & ~ent_q[i].op2.busy;
    end
  end

  rs_pick_lowest #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_pick (
    .req_in    (~busy_q),
    .found_out (free_found),
    .idx_out   (free_idx)
  );

  rs_pick_lowest #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_issue_pick (
    .req_in    (ready),
    .found_out (issue_found),
    .idx_out   (issue_idx)
  );

  assign rs_full_out = &busy_q;

  // Incoming op with its operands already snooped against this cycle's CDBs.
  always_comb begin
    new_ent        = '0;
    new_ent.openum = openum_e'(disp_openum_in);
    new_ent.op1    = snoop('{busy: disp_Q1_busy, tag: disp_Q1_in, val: disp_V1_in},
                           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
                           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
    new_ent.op2    = snoop('{busy: disp_Q2_busy, tag: disp_Q2_in, val: disp_V2_in},
                           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
                           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
    new_ent.imm    = disp_imm_in;
    new_ent.pc     = disp_pc_in;
    new_ent.rob_id = disp_rob_id_in;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted before any branch, so no path leaves one unassigned and no latch is inferred.
    busy_d    = busy_q;
    ent_d     = ent_q;
    ex_d      = ex_q;
    ex_d.openum = OPENUM_NOP;

    if (clear_in) begin
      busy_d = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          ent_d[i].op1 = snoop(ent_q[i].op1,
                               cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
                               cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
          ent_d[i].op2 = snoop(ent_q[i].op2,
                               cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
                               cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
        end
      end

      if (issue_found) begin
        ex_d.openum = ent_q[issue_idx].openum;
        ex_d.v1     = ent_q[issue_idx].op1.val;
        ex_d.v2     = ent_q[issue_idx].op2.val;
        ex_d.imm    = ent_q[issue_idx].imm;
        ex_d.pc     = ent_q[issue_idx].pc;
        ex_d.rob_id = ent_q[issue_idx].rob_id;
        busy_d[issue_idx] = FALSE;
      end

      // The free slot comes from pre-edge busy, so a slot freed by issue is never refilled this edge.
      if (disp_valid_in && free_found) begin
        ent_d[free_idx]  = new_ent;
        busy_d[free_idx] = TRUE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      busy_q <= '0;
      ex_q   <= '{openum: OPENUM_NOP, default: '0};
    end else begin
      busy_q <= busy_d;
      ex_q   <= ex_d;
    end
  end

  // NOTE: entry payload is left unreset; busy_q alone decides whether an entry's contents mean anything.
  always_ff @(posedge clk_in) begin
    ent_q <= ent_d;
  end

  assign ex_openum_out = ex_q.openum;
  assign ex_V1_out     = ex_q.v1;
  assign ex_V2_out     = ex_q.v2;
  assign ex_imm_out    = ex_q.imm;
  assign ex_pc_out     = ex_q.pc;
  assign ex_rob_id_out = ex_q.rob_id;

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Directed bench for rs_alu_scheduler: reset, latency, wakeup, bypass, full,
// issue order, clear and freeze, with hand-computed expectations.
module tb_rs_alu_scheduler;
  import rs_alu_scheduler_pkg::*;

  logic                clk_in = 1'b0;
  logic                rst_n;
  logic                rdy_in, clear_in;
  logic                disp_valid_in;
  logic [OPENUM_W-1:0] disp_openum_in;
  logic [DATA_W-1:0]   disp_V1_in, disp_V2_in;
  logic                disp_Q1_busy, disp_Q2_busy;
  logic [ROB_ID_W-1:0] disp_Q1_in, disp_Q2_in;
  logic [DATA_W-1:0]   disp_imm_in;
  logic [ADDR_W-1:0]   disp_pc_in;
  logic [ROB_ID_W-1:0] disp_rob_id_in;
  logic                cdb_alu_valid, cdb_lsb_valid;
  logic [ROB_ID_W-1:0] cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [DATA_W-1:0]   cdb_alu_value, cdb_lsb_value;
  logic                rs_full_out;
  logic [OPENUM_W-1:0] ex_openum_out;
  logic [DATA_W-1:0]   ex_V1_out, ex_V2_out, ex_imm_out;
  logic [ADDR_W-1:0]   ex_pc_out;
  logic [ROB_ID_W-1:0] ex_rob_id_out;

  int n_checks = 0;
  int n_fail   = 0;

  rs_alu_scheduler dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .rdy_in         (rdy_in),
    .clear_in       (clear_in),
    .disp_valid_in  (disp_valid_in),
    .disp_openum_in (disp_openum_in),
    .disp_V1_in     (disp_V1_in),
    .disp_V2_in     (disp_V2_in),
    .disp_Q1_busy   (disp_Q1_busy),
    .disp_Q2_busy   (disp_Q2_busy),
    .disp_Q1_in     (disp_Q1_in),
    .disp_Q2_in     (disp_Q2_in),
    .disp_imm_in    (disp_imm_in),
    .disp_pc_in     (disp_pc_in),
    .disp_rob_id_in (disp_rob_id_in),
    .cdb_alu_valid  (cdb_alu_valid),
    .cdb_alu_rob_id (cdb_alu_rob_id),
    .cdb_alu_value  (cdb_alu_value),
    .cdb_lsb_valid  (cdb_lsb_valid),
    .cdb_lsb_rob_id (cdb_lsb_rob_id),
    .cdb_lsb_value  (cdb_lsb_value),
    .rs_full_out    (rs_full_out),
    .ex_openum_out  (ex_openum_out),
    .ex_V1_out      (ex_V1_out),
    .ex_V2_out      (ex_V2_out),
    .ex_imm_out     (ex_imm_out),
    .ex_pc_out      (ex_pc_out),
    .ex_rob_id_out  (ex_rob_id_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_op(input string tag, input openum_e exp);
    check(tag, 32'(ex_openum_out), 32'(exp));
  endtask

  task automatic idle();
    rdy_in         = 1'b1;
    clear_in       = 1'b0;
    disp_valid_in  = 1'b0;
    disp_openum_in = '0;
    disp_V1_in     = '0;
    disp_V2_in     = '0;
    disp_Q1_busy   = 1'b0;
    disp_Q2_busy   = 1'b0;
    disp_Q1_in     = '0;
    disp_Q2_in     = '0;
    disp_imm_in    = '0;
    disp_pc_in     = '0;
    disp_rob_id_in = '0;
    cdb_alu_valid  = 1'b0;
    cdb_alu_rob_id = '0;
    cdb_alu_value  = '0;
    cdb_lsb_valid  = 1'b0;
    cdb_lsb_rob_id = '0;
    cdb_lsb_value  = '0;
  endtask

  task automatic disp(input openum_e op,
                      input logic [31:0] v1, input logic q1b, input logic [3:0] q1,
                      input logic [31:0] v2, input logic q2b, input logic [3:0] q2,
                      input logic [31:0] imm, input logic [3:0] rob);
    disp_valid_in  = 1'b1;
    disp_openum_in = op;
    disp_V1_in     = v1;
    disp_Q1_busy   = q1b;
    disp_Q1_in     = q1;
    disp_V2_in     = v2;
    disp_Q2_busy   = q2b;
    disp_Q2_in     = q2;
    disp_imm_in    = imm;
    disp_pc_in     = 32'h1000 + 32'(rob) * 4;
    disp_rob_id_in = rob;
  endtask

  task automatic alu_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_alu_valid  = 1'b1;
    cdb_alu_rob_id = tag;
    cdb_alu_value  = val;
  endtask

  task automatic lsb_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_lsb_valid  = 1'b1;
    cdb_lsb_rob_id = tag;
    cdb_lsb_value  = val;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check_op("rst_op", OPENUM_NOP);
    check("rst_full", 32'(rs_full_out), 32'd0);
    check("rst_v1", ex_V1_out, 32'd0);
    check("rst_rob", 32'(ex_rob_id_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: reset mid-stream with three pending entries and a live issue
    disp(OPENUM_ADD, 0, 1, 4'd7, 0, 0, 0, 0, 4'd1); tick();
    disp(OPENUM_ADD, 0, 1, 4'd7, 0, 0, 0, 0, 4'd2); tick();
    disp(OPENUM_ADD, 0, 1, 4'd7, 0, 0, 0, 0, 4'd3); tick();
    disp(OPENUM_ADD, 32'h44, 0, 0, 32'h55, 0, 0, 0, 4'd4); tick();
    idle(); tick();
    check_op("t1_pre_op", OPENUM_ADD);
    check("t1_pre_rob", 32'(ex_rob_id_out), 32'd4);
    check("t1_pre_v1", ex_V1_out, 32'h44);
    rst_n = 1'b0;
    #1;
    check_op("t1_rst_op", OPENUM_NOP);
    check("t1_rst_full", 32'(rs_full_out), 32'd0);
    check("t1_rst_v1", ex_V1_out, 32'd0);
    #2;
    rst_n = 1'b1;
    alu_cdb(4'd7, 32'h77); tick();
    idle(); tick();
    check_op("t1_post_op0", OPENUM_NOP);
    tick();
    check_op("t1_post_op1", OPENUM_NOP);

    // 2: ready ADDI latency
    disp(OPENUM_ADDI, 32'd5, 0, 0, 0, 0, 0, 32'd7, 4'd2); tick();
    idle();
    check_op("t2_lat0", OPENUM_NOP);
    tick();
    check_op("t2_op", OPENUM_ADDI);
    check("t2_v1", ex_V1_out, 32'd5);
    check("t2_imm", ex_imm_out, 32'd7);
    check("t2_rob", 32'(ex_rob_id_out), 32'd2);
    check("t2_pc", ex_pc_out, 32'h1008);
    tick();
    check_op("t2_after", OPENUM_NOP);

    // 3: Q1 wakeup from ALU CDB; LSB CDB carries same tag and must lose
    disp(OPENUM_ADD, 0, 1, 4'd3, 32'h20, 0, 0, 0, 4'd4); tick();
    idle();
    check_op("t3_wait0", OPENUM_NOP);
    tick();
    check_op("t3_wait1", OPENUM_NOP);
    alu_cdb(4'd3, 32'h10);
    lsb_cdb(4'd3, 32'h99);
    tick();
    idle();
    check_op("t3_wake_edge", OPENUM_NOP);
    tick();
    check_op("t3_op", OPENUM_ADD);
    check("t3_v1", ex_V1_out, 32'h10);
    check("t3_v2", ex_V2_out, 32'h20);
    check("t3_rob", 32'(ex_rob_id_out), 32'd4);

    // 4: same-cycle bypass on Q2 from LSB CDB
    disp(OPENUM_SUB, 32'd1, 0, 0, 0, 1, 4'd5, 0, 4'd6);
    lsb_cdb(4'd5, 32'hFF);
    tick();
    idle();
    check_op("t4_lat0", OPENUM_NOP);
    tick();
    check_op("t4_op", OPENUM_SUB);
    check("t4_v2", ex_V2_out, 32'hFF);
    check("t4_v1", ex_V1_out, 32'd1);
    check("t4_rob", 32'(ex_rob_id_out), 32'd6);
    tick();

    // 5: fill all 16 pending, drop 17th, wake 9 then 2
    for (int i = 0; i < RS_SIZE; i++) begin
      disp(OPENUM_ADD, 32'(i), 1, 4'(i), 0, 0, 0, 0, 4'(i));
      tick();
      if (i == RS_SIZE - 2) check("t5_full_at15", 32'(rs_full_out), 32'd0);
    end
    check("t5_full", 32'(rs_full_out), 32'd1);
    check_op("t5_fill_op", OPENUM_NOP);
    disp(OPENUM_XOR, 32'hAA, 0, 0, 32'hBB, 0, 0, 0, 4'd15); tick();
    idle();
    check_op("t5_drop0", OPENUM_NOP);
    check("t5_full_still", 32'(rs_full_out), 32'd1);
    tick();
    check_op("t5_drop1", OPENUM_NOP);
    alu_cdb(4'd9, 32'h900); tick();
    idle();
    lsb_cdb(4'd2, 32'h200);
    check_op("t5_wake9_edge", OPENUM_NOP);
    tick();
    idle();
    check_op("t5_iss9_op", OPENUM_ADD);
    check("t5_iss9_rob", 32'(ex_rob_id_out), 32'd9);
    check("t5_iss9_v1", ex_V1_out, 32'h900);
    check("t5_full_after", 32'(rs_full_out), 32'd0);
    tick();
    check("t5_iss2_rob", 32'(ex_rob_id_out), 32'd2);
    check("t5_iss2_v1", ex_V1_out, 32'h200);
    tick();
    check_op("t5_done", OPENUM_NOP);

    // 6: clear with concurrent dispatch and wakeup, then rdy_in freeze
    clear_in = 1'b1; tick();
    idle();
    check("t6_clear0_full", 32'(rs_full_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      disp(OPENUM_AND, 32'(i), 1, 4'd12, 0, 0, 0, 0, 4'(i));
      tick();
    end
    check("t6_eight_full", 32'(rs_full_out), 32'd0);
    clear_in = 1'b1;
    disp(OPENUM_ADD, 32'h33, 0, 0, 0, 0, 0, 0, 4'd3);
    alu_cdb(4'd12, 32'hC0);
    tick();
    idle();
    check_op("t6_clr_op", OPENUM_NOP);
    check("t6_clr_full", 32'(rs_full_out), 32'd0);
    tick();
    check_op("t6_clr_op1", OPENUM_NOP);
    tick();
    check_op("t6_clr_op2", OPENUM_NOP);

    disp(OPENUM_OR, 32'hAB, 0, 0, 0, 0, 0, 0, 4'd10); tick();
    idle();
    rdy_in = 1'b0;
    disp(OPENUM_XOR, 32'hCD, 0, 0, 0, 0, 0, 0, 4'd11);
    tick();
    check_op("t6_frz_op0", OPENUM_NOP);
    check("t6_frz_full", 32'(rs_full_out), 32'd0);
    tick();
    check_op("t6_frz_op1", OPENUM_NOP);
    idle();
    tick();
    check_op("t6_thaw_op", OPENUM_OR);
    check("t6_thaw_rob", 32'(ex_rob_id_out), 32'd10);
    check("t6_thaw_v1", ex_V1_out, 32'hAB);
    tick();
    check_op("t6_thaw_after", OPENUM_NOP);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
